inst_prefetch: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the pipeline's IF stage; supplies the instruction word and its PC.
- Issues sequential word fetches to instruction memory over a req/gnt + rvalid handshake and buffers in-order responses in a DEPTH-entry queue.
- Presents {pc, inst} to IF with a valid flag, honours the load-use stall, and flushes/re-steers on a taken jump or branch redirect from EX.

---
 rtl/ipf_pkg.sv | 25 ++
 rtl/inst_prefetch_if.sv | 33 +++
 rtl/ipf_fifo.sv | 58 +++++
 rtl/inst_prefetch.sv | 124 ++++++++++++
 tb/tb_inst_prefetch.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ipf_pkg.sv
// ipf_pkg: shared constants, state encoding and queue entry type for the
// instruction prefetch front end.
package ipf_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } ipf_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ipf_entry_t;

  // Sequential word step; wraps modulo 2^32 by construction.
  function automatic logic [XLEN-1:0] nextPc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/inst_prefetch_if.sv
// inst_prefetch_if: redirect/stall control from the pipeline, the imem
// req/gnt/rvalid bus and the IF-facing instruction output, as one bundle.
interface inst_prefetch_if;
  import ipf_pkg::*;

  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            stall_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            if_valid_o;
  logic [XLEN-1:0] if_pc_o;
  logic [XLEN-1:0] if_inst_o;

  // master = the prefetch unit, slave = pipeline plus instruction memory
  modport master (
    input  redirect_i, redirect_pc_i, stall_i,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output imem_req_o, imem_addr_o,
    output if_valid_o, if_pc_o, if_inst_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, stall_i,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o,
    input  if_valid_o, if_pc_o, if_inst_o
  );

endinterface

// File: rtl/ipf_fifo.sv
// ipf_fifo: DEPTH-entry in-order queue of {pc, inst} with push, pop and a
// single-cycle flush; asynchronous active-low reset on the 'reset' port.
module ipf_fifo
  import ipf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  ipf_entry_t               i_pushData,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output ipf_entry_t               o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  ipf_entry_t       r_mem [DEPTH];
  logic [AW-1:0]    r_rdPtr;
  logic [AW-1:0]    r_wrPtr;
  logic [AW:0]      r_count;
  logic             w_doPop;
  logic             w_doPush;

  assign w_doPop  = i_pop && !i_flush && (r_count != '0);
  assign w_doPush = i_push && !i_flush && ((r_count < (AW+1)'(DEPTH)) || w_doPop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_prefetch.sv
// inst_prefetch: sequential instruction fetch with credit-limited requests, an
// in-order response queue, and redirect flush. IPF_BYPASS_EN adds an empty-queue bypass.
module inst_prefetch
  import ipf_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  inst_prefetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  ipf_state_t      r_state;
  ipf_state_t      w_stateNext;
  logic [XLEN-1:0] r_fetchPc;
  logic [XLEN-1:0] r_respPc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   w_discardNext;
  logic [CW-1:0]   w_drainLeft;
  logic [CW:0]     w_inflight;
  logic [CW-1:0]   w_count;
  ipf_entry_t      w_head;
  ipf_entry_t      w_pushData;
  logic            w_req;
  logic            w_hs;
  logic            w_accept;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;

  assign w_inflight  = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_req       = (r_state != BOOT) && (w_inflight < (CW+1)'(DEPTH));
  assign w_hs        = w_req && bus.imem_gnt_i;
  // Responses still owed by memory after this cycle; on redirect all are stale.
  assign w_drainLeft = r_outstanding + CW'(w_hs) - CW'(bus.imem_rvalid_i);
  assign w_accept    = bus.imem_rvalid_i && (r_discard == '0) && !bus.redirect_i;

`ifdef IPF_BYPASS_EN
  assign w_bypass = (w_count == '0) && (r_discard == '0) && bus.imem_rvalid_i && !bus.redirect_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push     = w_accept && !(w_bypass && !bus.stall_i);
  assign w_pop      = (w_count != '0) && !bus.stall_i && !bus.redirect_i;
  assign w_pushData = '{pc: r_respPc, inst: bus.imem_rdata_i};

  ipf_fifo #(
    .DEPTH (DEPTH)
  ) uFifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_pushData (w_pushData),
    .i_pop      (w_pop),
    .i_flush    (bus.redirect_i),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= BOOT;
      r_fetchPc     <= RESET_PC;
      r_respPc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_state       <= w_stateNext;
      r_discard     <= w_discardNext;
      r_outstanding <= w_drainLeft;
      if (bus.redirect_i) begin
        r_fetchPc <= bus.redirect_pc_i;
        r_respPc  <= bus.redirect_pc_i;
      end else begin
        if (w_hs)     r_fetchPc <= nextPc(r_fetchPc);
        if (w_accept) r_respPc  <= nextPc(r_respPc);
      end
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_discardNext = r_discard;
    if (bus.redirect_i)
      w_discardNext = w_drainLeft;
    else if (bus.imem_rvalid_i && (r_discard != '0))
      w_discardNext = r_discard - CW'(1);
    unique case (r_state)
      BOOT:    w_stateNext = RUN;
      RUN:     if (bus.redirect_i && (w_drainLeft != '0)) w_stateNext = FLUSH;
      FLUSH:   if (w_discardNext == '0) w_stateNext = RUN;
      default: w_stateNext = BOOT;
    endcase
  end

  assign bus.imem_req_o  = w_req;
  assign bus.imem_addr_o = r_fetchPc;

  // An empty queue presents the reset PC and a NOP so IF never sees stale data.
  always_comb begin
    bus.if_valid_o = (w_count != '0);
    bus.if_pc_o    = (w_count != '0) ? w_head.pc   : RESET_PC;
    bus.if_inst_o  = (w_count != '0) ? w_head.inst : NOP_INST;
`ifdef IPF_BYPASS_EN
    if (w_bypass) begin
      bus.if_valid_o = 1'b1;
      bus.if_pc_o    = r_respPc;
      bus.if_inst_o  = bus.imem_rdata_i;
    end
`endif
  end

  aRvalidHasOutstanding: assert property (@(posedge clk) disable iff (!reset)
    bus.imem_rvalid_i |-> (r_outstanding != '0));

  aQueueNoOverflow: assert property (@(posedge clk) disable iff (!reset)
    (w_push && !w_pop) |-> (w_count < CW'(DEPTH)));

endmodule

// File: tb/tb_inst_prefetch.sv
// tb_inst_prefetch: directed and randomized checks of inst_prefetch against an
// expected-PC-stream scoreboard; memory returns each word address as its data.
module tb_inst_prefetch;
  import ipf_pkg::*;

  localparam int              DEPTH    = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
`ifdef IPF_BYPASS_EN
  localparam int FIRST_VALID_EDGE = 2;
`else
  localparam int FIRST_VALID_EDGE = 3;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  inst_prefetch_if bus();

  inst_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int              checks    = 0;
  int              failures  = 0;
  int              popCount  = 0;
  int              respPct   = 100;
  logic [XLEN-1:0] expQ[$];
  logic [XLEN-1:0] expTail;
  logic [XLEN-1:0] memQ[$];
  bit              memHs;
  bit              memRv;
  logic [XLEN-1:0] memAddr;
  bit              prevRedirect = 1'b0;

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                             input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: wait expired at %0t", name, $time);
  endtask

  // A new fetch epoch (reset or redirect) restarts the expected PC stream.
  task automatic newEpoch(input logic [XLEN-1:0] pc);
    expQ.delete();
    expTail = pc;
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(expTail);
      expTail = expTail + 32'd4;
    end
  endtask

  task automatic applyStimulus(input bit rd, input logic [XLEN-1:0] rpc,
                               input bit st, input bit g);
    @(posedge clk);
    #2;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    bus.stall_i       = st;
    bus.imem_gnt_i    = g;
    if (rd) newEpoch(rpc);
    expQ.push_back(expTail);
    expTail = expTail + 32'd4;
  endtask

  task automatic doReset(input bit g);
    @(posedge clk);
    #2;
    reset             = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.stall_i       = 1'b0;
    bus.imem_gnt_i    = g;
    newEpoch(RESET_PC);
    @(negedge clk);
    checkOutput("reset_req", 32'(bus.imem_req_o), 32'd0);
    checkOutput("reset_valid", 32'(bus.if_valid_o), 32'd0);
    checkOutput("reset_pc", bus.if_pc_o, RESET_PC);
    checkOutput("reset_inst", bus.if_inst_o, NOP_INST);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("boot_no_req", 32'(bus.imem_req_o), 32'd0);
  endtask

  // Instruction memory: in-order, returns the word address as the data.
  always @(negedge clk) begin
    memHs   = reset && bus.imem_req_o && bus.imem_gnt_i;
    memAddr = bus.imem_addr_o;
    memRv   = bus.imem_rvalid_i;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      memQ.delete();
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = '0;
    end else begin
      if (memRv && (memQ.size() > 0)) void'(memQ.pop_front());
      if (memHs) memQ.push_back(memAddr);
      #1;
      if ((memQ.size() > 0) && ($urandom_range(99, 0) < respPct)) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = memQ[0];
      end else begin
        bus.imem_rvalid_i = 1'b0;
      end
    end
  end

  // Every presented instruction must be the head of the expected stream.
  always @(negedge clk) begin
    if (!reset) begin
      prevRedirect = 1'b0;
    end else begin
      if (prevRedirect) checkOutput("valid_after_redirect", 32'(bus.if_valid_o), 32'd0);
      if (bus.if_valid_o && !bus.redirect_i) begin
        if (expQ.size() == 0) begin
          failTimeout("scoreboard_empty");
        end else begin
          checkOutput("if_pc", bus.if_pc_o, expQ[0]);
          checkOutput("if_inst", bus.if_inst_o, expQ[0]);
          if (!bus.stall_i) begin
            void'(expQ.pop_front());
            popCount++;
          end
        end
      end
      prevRedirect = bus.redirect_i;
    end
  end

  initial begin
    int  firstK;
    int  validRun;
    bit  found;
    bit  granted;
    bit  rd;
    logic [XLEN-1:0] rpc;

    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.stall_i       = 1'b0;
    bus.imem_gnt_i    = 1'b0;
    newEpoch(RESET_PC);
    repeat (2) @(posedge clk);

    // Latency from reset release and sustained one-per-cycle throughput.
    doReset(1'b1);
    firstK = 0;
    for (int k = 1; k <= 8 && firstK == 0; k++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      if (bus.if_valid_o) firstK = k;
    end
    checkOutput("first_valid_edge", 32'(firstK), 32'(FIRST_VALID_EDGE));
    validRun = (firstK != 0) ? 1 : 0;
    repeat (15) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      if (bus.if_valid_o) validRun++;
    end
    checkOutput("throughput_16", 32'(validRun), 32'd16);

    // Address must hold while the request waits for a grant.
    doReset(1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("nogrant_req", 32'(bus.imem_req_o), 32'd1);
      checkOutput("nogrant_addr", bus.imem_addr_o, 32'h0);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("grant_addr", bus.imem_addr_o, 32'h0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("after_grant_addr", bus.imem_addr_o, 32'h4);

    // Long stall fills the queue and throttles requests.
    repeat (6) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    repeat (10) applyStimulus(1'b0, '0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("stall_req_drop", 32'(bus.imem_req_o), 32'd0);
    checkOutput("stall_valid_held", 32'(bus.if_valid_o), 32'd1);
    validRun = 0;
    repeat (8) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      if (bus.if_valid_o) validRun++;
    end
    checkOutput("stall_release_nogap", 32'(validRun), 32'd8);

    // Redirect with two responses still owed by memory.
    doReset(1'b0);
    respPct = 0;
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
    respPct = 100;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      if (bus.if_valid_o) begin
        found = 1'b1;
        checkOutput("first_pc_after_flush", bus.if_pc_o, 32'h100);
      end
    end
    if (!found) failTimeout("flush_first_valid");

    // Redirect coinciding with a response and a pop.
    repeat (6) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("redirect_cycle_rvalid", 32'(bus.imem_rvalid_i), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("redirect_next_valid", 32'(bus.if_valid_o), 32'd0);
    checkOutput("redirect_next_addr", bus.imem_addr_o, 32'h100);

    // Fetch address wraps past the top of the address space.
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("wrap_addr_pre", bus.imem_addr_o, 32'hFFFF_FFFC);
    granted = bus.imem_req_o;
    for (int i = 0; i < 10 && !granted; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      granted = bus.imem_req_o;
    end
    if (!granted) failTimeout("wrap_grant");
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("wrap_addr_post", bus.imem_addr_o, 32'h0);
    repeat (6) applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic with a mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) respPct = $urandom_range(100, 50);
      if (c == 1500) doReset(1'($urandom_range(1, 0)));
      rd  = ($urandom_range(39, 0) == 0);
      rpc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      applyStimulus(rd, rpc, ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) != 0));
    end

    respPct = 100;
    repeat (20) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    validRun = 0;
    repeat (10) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      if (bus.if_valid_o) validRun++;
    end
    checkOutput("drain_steady_valid", 32'(validRun), 32'd10);
    checks++;
    if (popCount < 1000) begin
      failures++;
      $display("[TB] FAIL consumed_total: got %0d expected at least 1000", popCount);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
